// File: rtl/gamma_lut_stream.sv
// rtl/gamma_lut_stream.sv - double-banked per-channel gamma lookup on a valid/ready pixel stream
module gamma_lut_stream #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 12,
    parameter int CHANNELS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [IN_W-1:0]           cfg_addr,
    input  logic [OUT_W-1:0]          cfg_data,
    input  logic                      cfg_swap,
    input  logic                      cfg_enable,
    output logic                      swap_pending,
    output logic                      active_bank,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sof,
    input  logic [CHANNELS*IN_W-1:0]  in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sof,
    output logic [CHANNELS*OUT_W-1:0] out_data
);
    localparam int DEPTH = 2 ** (IN_W + 1);

    logic                      advance;
    logic                      accept;
    logic                      swap_now;
    logic                      rd_bank;
    logic                      wr_en;
    logic [IN_W:0]             wr_addr;
    logic                      s1_valid;
    logic                      s1_sof;
    logic                      s1_enable;
    logic [CHANNELS*IN_W-1:0]  s1_data;
    logic [CHANNELS*OUT_W-1:0] lut_data;
    logic [CHANNELS*OUT_W-1:0] bypass_data;

    // MSB replication, repeated as often as needed to fill OUT_W
    function automatic logic [OUT_W-1:0] expand(input logic [IN_W-1:0] v);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int b = 0; b < OUT_W; b++) begin
            r[OUT_W-1-b] = v[IN_W-1-(b % IN_W)];
        end
        return r;
    endfunction

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;
    // A swap requested in the same cycle as an sof beat still applies to that beat
    assign swap_now = accept && in_sof && (swap_pending || cfg_swap);
    assign rd_bank  = swap_now ? ~active_bank : active_bank;
    assign wr_en    = cfg_we && !swap_pending;
    assign wr_addr  = {~active_bank, cfg_addr};

    always_ff @(posedge clk) begin
        if (reset) begin
            swap_pending <= 1'b0;
            active_bank  <= 1'b0;
        end else if (swap_now) begin
            swap_pending <= 1'b0;
            active_bank  <= ~active_bank;
        end else if (cfg_swap) begin
            swap_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_enable <= 1'b0;
            s1_data   <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_sof    <= in_valid && in_sof;
            s1_enable <= cfg_enable;
            s1_data   <= in_data;
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [OUT_W-1:0] mem [DEPTH];
        logic [OUT_W-1:0] rd_q;

        // Read address only moves on advance, so a stalled result stays put
        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_addr] <= cfg_data;
            end
            if (advance) begin
                rd_q <= mem[{rd_bank, in_data[ch*IN_W +: IN_W]}];
            end
        end

        assign lut_data[ch*OUT_W +: OUT_W]    = rd_q;
        assign bypass_data[ch*OUT_W +: OUT_W] = expand(s1_data[ch*IN_W +: IN_W]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            out_sof   <= s1_sof;
            out_data  <= s1_enable ? lut_data : bypass_data;
        end
    end
endmodule

// File: tb/tb_gamma_lut_stream.sv
// tb/tb_gamma_lut_stream.sv - randomized and directed bench for gamma_lut_stream with a queue-based model
module tb_gamma_lut_stream;
    localparam int IN_W  = 8;
    localparam int OUT_W = 12;
    localparam int CH    = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_we = 1'b0;
    logic [IN_W-1:0]   cfg_addr = '0;
    logic [OUT_W-1:0]  cfg_data = '0;
    logic              cfg_swap = 1'b0;
    logic              cfg_enable = 1'b0;
    logic              swap_pending;
    logic              active_bank;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sof = 1'b0;
    logic [CH*IN_W-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_sof;
    logic [CH*OUT_W-1:0] out_data;

    gamma_lut_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CH)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_swap(cfg_swap), .cfg_enable(cfg_enable),
        .swap_pending(swap_pending), .active_bank(active_bank),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: table contents, bank state and expected output order
    logic [OUT_W-1:0] tbl [2][256];
    bit               m_bank = 0;
    bit               m_pending = 0;
    logic [CH*OUT_W:0] expq[$];
    bit               armed = 0;
    bit               held = 0;
    logic [CH*OUT_W:0] held_v;
    logic [CH*OUT_W:0] e;
    bit               pend_eff;

    function automatic logic [OUT_W-1:0] byp(input logic [IN_W-1:0] v);
        return {v, v[7:4]};
    endfunction

    function automatic logic [CH*OUT_W-1:0] model_out(input logic [CH*IN_W-1:0] d, input bit en, input bit bk);
        logic [CH*OUT_W-1:0] r;
        logic [IN_W-1:0] v;
        for (int c = 0; c < CH; c++) begin
            v = d[c*IN_W +: IN_W];
            r[c*OUT_W +: OUT_W] = en ? tbl[bk][v] : byp(v);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            chk("swap_pending", swap_pending, m_pending);
            chk("active_bank", active_bank, m_bank);
            if (out_valid && out_ready && !reset) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", out_data, e[CH*OUT_W-1:0]);
                    chk("out_sof", out_sof, e[CH*OUT_W]);
                end
            end
            if (held && out_valid && !reset) chk("stall_stable", {out_sof, out_data}, held_v);
            if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
            held   = out_valid && !out_ready;
            held_v = {out_sof, out_data};
            if (reset) begin
                m_bank = 0;
                m_pending = 0;
                expq.delete();
                held = 0;
            end else begin
                pend_eff = m_pending || cfg_swap;
                if (cfg_we && !m_pending) tbl[!m_bank][cfg_addr] = cfg_data;
                if (in_valid && in_ready) begin
                    if (in_sof && pend_eff) begin
                        m_bank = !m_bank;
                        pend_eff = 0;
                    end
                    expq.push_back({in_sof, model_out(in_data, cfg_enable, m_bank)});
                end
                m_pending = pend_eff;
            end
        end
    end

    int mode = 0;
    int stall_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (mode == 0) begin
            out_ready = 1'b1;
        end else if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else if ($urandom % 8 == 0) begin
            out_ready = 1'b0;
            stall_cnt = 4;
        end else begin
            out_ready = ($urandom % 3 != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input bit sof, input logic [CH*IN_W-1:0] d, input bit en);
        bit done = 0;
        in_valid   = 1'b1;
        in_sof     = sof;
        in_data    = d;
        cfg_enable = en;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            step();
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic cfg_write(input logic [IN_W-1:0] a, input logic [OUT_W-1:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_swap();
        cfg_swap = 1'b1;
        step();
        cfg_swap = 1'b0;
    endtask

    // Single beat with out_ready high: invisible after acceptance, visible one cycle later, then gone
    task automatic lit_beat(input logic [CH*IN_W-1:0] d, input bit en, input logic [CH*OUT_W-1:0] exp, input string name);
        send_beat(0, d, en);
        in_valid = 1'b0;
        chk({name, "_lat_early"}, out_valid, 0);
        step();
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_data"}, out_data, exp);
        step();
        chk({name, "_one_cycle"}, out_valid, 0);
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        armed = 1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_bank", active_bank, 0);
        chk("rst_pending", swap_pending, 0);

        lit_beat(24'hFF8000, 0, 36'hFFF808000, "bypass");

        for (int i = 0; i < 256; i++) cfg_write(i[7:0], 12'(16 * i));
        pulse_swap();
        chk("t2_pending_set", swap_pending, 1);
        send_beat(1, {3{8'h10}}, 1);
        chk("t2_pending_clr", swap_pending, 0);
        chk("t2_bank1", active_bank, 1);
        for (int i = 0; i < 3; i++) send_beat(0, 24'($urandom), 1);
        in_valid = 1'b0;
        repeat (3) step();
        lit_beat({3{8'h10}}, 1, {3{12'h100}}, "lut_0x10");

        for (int i = 0; i < 256; i++) cfg_write(i[7:0], (i == 16) ? 12'h5A5 : 12'($urandom));
        send_beat(1, 24'($urandom), 1);
        for (int i = 0; i < 2; i++) send_beat(0, 24'($urandom), 1);
        in_valid = 1'b0;
        pulse_swap();
        for (int i = 0; i < 3; i++) send_beat(0, 24'($urandom), 1);
        chk("t3_mid_pending", swap_pending, 1);
        chk("t3_mid_bank", active_bank, 1);
        send_beat(1, {3{8'h10}}, 1);
        in_valid = 1'b0;
        chk("t3_pending_clr", swap_pending, 0);
        chk("t3_bank0", active_bank, 0);
        step();
        chk("t3_sof_valid", out_valid, 1);
        chk("t3_sof_data", out_data, {3{12'h5A5}});
        repeat (3) step();

        pulse_swap();
        cfg_write(8'h20, 12'hABC);
        send_beat(1, 24'h0, 0);
        in_valid = 1'b0;
        chk("t4_bank1", active_bank, 1);
        repeat (3) step();
        lit_beat({3{8'h20}}, 1, {3{12'h200}}, "blocked_write");

        pulse_swap();
        mode = 1;
        stall_cnt = 5;
        for (int i = 0; i < 16; i++) send_beat($urandom % 5 == 0, 24'($urandom), $urandom % 2 == 1);
        in_valid = 1'b0;
        for (int k = 0; k < 500 && expq.size() != 0; k++) step();
        chk("t5_drain", expq.size(), 0);
        mode = 0;
        repeat (3) step();

        pulse_swap();
        chk("t6_pending_set", swap_pending, 1);
        send_beat(0, 24'($urandom), 1);
        send_beat(0, 24'($urandom), 0);
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_pending", swap_pending, 0);
        chk("t6_bank", active_bank, 0);
        chk("t6_in_ready", in_ready, 1);
        lit_beat(24'h123456, 0, 36'h121343565, "post_reset");
        repeat (2) step();
        chk("final_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
